// File: rtl/div_iter.sv
// Iterative signed divider (non-restoring on magnitudes, then sign fix-up).
// Latency: 34 enabled edges from start to the ready pulse (WIDTH+2); no early exit.
// Backpressure: none; enable low freezes all state, start restarts at any time.
// Optional remainder port and its FIX-stage logic: define DIV_REMAINDER_EN.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] div_result,
  output logic             div_exception,
  output logic             div_resultrdy
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] div_remainder
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial remainder carries one extra bit so it can go negative and still
  // hold magnitudes up to 2^(WIDTH-1).
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   b_q, b_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   p_fix;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   p_step;

  // Next-state logic: one quotient bit per RUN cycle, sign fix in FIX,
  // output capture in DONE; start overrides the state from anywhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    b_d     = b_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    p_step  = shifted;
`ifdef DIV_REMAINDER_EN
    rem_d   = rem_q;
    p_fix   = p_q;
`endif

    case (state_q)
      S_RUN: begin
        // The sign before the shift decides subtract/add; the shift cannot
        // overflow because |P| < |B| <= 2^(WIDTH-1).
        if (!p_q[WIDTH]) p_step = shifted - b_q;
        else             p_step = shifted + b_q;
        p_d   = p_step;
        q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q)        q_d = '0;
        else if (ovf_q)  q_d = MIN_NEG;
        else if (sgnq_q) q_d = -q_q;
`ifdef DIV_REMAINDER_EN
        // With a zero divisor every step subtracts 0, so P ends as |A| and
        // the dividend-sign negation naturally returns A as the remainder.
        p_fix = p_q[WIDTH] ? (p_q + b_q) : p_q;
        if (ovf_q)       p_d = '0;
        else if (sgnr_q) p_d = -p_fix;
        else             p_d = p_fix;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        res_d   = q_q;
        exc_d   = dz_q | ovf_q;
        rdy_d   = 1'b1;
`ifdef DIV_REMAINDER_EN
        rem_d   = p_q[WIDTH-1:0];
`endif
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (start) begin
      // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is
      // exactly right when read as unsigned.
      q_d     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      b_d     = {1'b0, (data_operandB[WIDTH-1] ? -data_operandB : data_operandB)};
      p_d     = '0;
      sgnq_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      sgnr_d  = data_operandA[WIDTH-1];
      dz_d    = (data_operandB == '0);
      ovf_d   = (data_operandA == MIN_NEG) && (data_operandB == '1);
      cnt_d   = '0;
      state_d = S_RUN;
    end
  end

  // State registers; enable low freezes everything, including the ready pulse.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef DIV_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      b_q     <= b_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
`ifdef DIV_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign div_result    = res_q;
  assign div_exception = exc_q;
  assign div_resultrdy = rdy_q;
`ifdef DIV_REMAINDER_EN
  assign div_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: vector table plus hand-built enable/restart/clear sequences.
// Results are matched through an expectation queue popped on each ready pulse.
module tb_div_iter;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        enable = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] div_result;
  logic        div_exception;
  logic        div_resultrdy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] div_remainder;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int rdy_seen = 0;
  int ops_expected = 0;
  logic [31:0] last_q = '0;
  vec_t sb[$];
  vec_t tbl[12];

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock),
    .clear(clear),
    .enable(enable),
    .start(start),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .div_result(div_result),
    .div_exception(div_exception),
    .div_resultrdy(div_resultrdy)
`ifdef DIV_REMAINDER_EN
    ,
    .div_remainder(div_remainder)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive start for one edge (E0) and record the expected outcome.
  task automatic do_start(input vec_t v);
    data_operandA = v.a;
    data_operandB = v.b;
    start = 1'b1;
    sb.push_back(v);
    ops_expected++;
    tick();
    start = 1'b0;
  endtask

  // Count edges from E0 until ready shows, then confirm it is a one-cycle pulse.
  task automatic wait_rdy(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!div_resultrdy && n < 100) begin
      tick();
      n++;
    end
    chk(name, n, exp_lat);
    tick();
    chk({name, "_pulse_end"}, {31'd0, div_resultrdy}, 32'd0);
  endtask

  // Scoreboard: compare every ready pulse against the oldest expectation.
  always @(negedge clock) begin
    if (!clear && div_resultrdy) begin
      rdy_seen++;
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_ready: ready high with no operation pending");
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("result", div_result, e.q);
        chk("exception", {31'd0, div_exception}, {31'd0, e.exc});
`ifdef DIV_REMAINDER_EN
        chk("remainder", div_remainder, e.r);
`endif
        last_q = e.q;
      end
    end
  end

  initial begin
    vec_t v;
    logic signed [31:0] sa, sbv;

    tbl[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    tbl[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    tbl[3]  = '{32'd5,        32'd0,        32'd0,        32'd5,        1'b1};
    tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1};
    tbl[5]  = '{32'hFFFFFFFB, 32'd0,        32'd0,        32'hFFFFFFFB, 1'b1};
    tbl[6]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
    tbl[7]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0};
    tbl[8]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0};
    tbl[9]  = '{32'h80000000, 32'd7,        32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0};
    tbl[10] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    tbl[11] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};

    // Reset state
    #2;
    chk("reset_result", div_result, 32'd0);
    chk("reset_exception", {31'd0, div_exception}, 32'd0);
    chk("reset_ready", {31'd0, div_resultrdy}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("reset_remainder", div_remainder, 32'd0);
`endif
    tick();
    clear = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      do_start(tbl[i]);
      wait_rdy("latency", 34);
    end

    // Random vectors against the language's own signed division
    for (int i = 0; i < 6; i++) begin
      v.a = $urandom;
      v.b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (v.b == 32'd0) v.b = 32'd3;
      if (v.b == 32'hFFFFFFFF) v.b = 32'd5;
      sa = v.a;
      sbv = v.b;
      v.q = sa / sbv;
      v.r = sa % sbv;
      v.exc = 1'b0;
      do_start(v);
      wait_rdy("rand_latency", 34);
    end

    // Enable low for 5 cycles mid-RUN; outputs hold the previous result
    v = '{32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
    do_start(v);
    for (int i = 0; i < 9; i++) tick();
    chk("hold_result", div_result, last_q);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b1;
    begin
      int n;
      n = 14;
      while (!div_resultrdy && n < 100) begin
        tick();
        n++;
      end
      chk("enable_latency", n, 39);
      tick();
    end

    // Restart mid-RUN: the first operation must never report
    v = '{32'd50, 32'd5, 32'd10, 32'd0, 1'b0};
    do_start(v);
    for (int i = 0; i < 9; i++) tick();
    void'(sb.pop_back());
    ops_expected--;
    v = '{32'd9, 32'd2, 32'd4, 32'd1, 1'b0};
    do_start(v);
    wait_rdy("restart_latency", 34);

    // Clear mid-operation: outputs drop asynchronously, no ready follows
    v = '{32'd123, 32'd4, 32'd30, 32'd3, 1'b0};
    do_start(v);
    for (int i = 0; i < 19; i++) tick();
    clear = 1'b1;
    #2;
    chk("clear_result", div_result, 32'd0);
    chk("clear_exception", {31'd0, div_exception}, 32'd0);
    chk("clear_ready", {31'd0, div_resultrdy}, 32'd0);
`ifdef DIV_REMAINDER_EN
    chk("clear_remainder", div_remainder, 32'd0);
`endif
    void'(sb.pop_back());
    ops_expected--;
    tick();
    tick();
    clear = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("no_ready_after_clear", rdy_seen, ops_expected);

    v = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0};
    do_start(v);
    wait_rdy("post_clear_latency", 34);

    tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("ready_count", rdy_seen, ops_expected);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
